// File: rtl/arb_pkg.sv
// Shared definitions for the 8-line round-robin request arbiter.
//   N_REQ     : number of request lines (fixed at 8)
//   IDX_W     : width of a request index / pointer
//   state_t   : arbiter FSM state encoding
//   rr_pick   : rotating-priority one-hot selection of a request vector
//   onehot_idx: binary index of a one-hot vector
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set bit of vec scanning ptr, ptr+1, ... with modulo-8 wrap,
  // returned as a one-hot vector (all-zero when vec is empty).
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                               input logic [IDX_W-1:0] ptr);
    logic [N_REQ-1:0] oh;
    logic [IDX_W-1:0] idx;
    logic             found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // 3-bit addition wraps naturally past index 7
      idx = ptr + IDX_W'(i);
      if (!found && vec[idx]) begin
        oh[idx] = 1'b1;
        found   = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority one-hot selector.
//   vec    : candidate request vector
//   ptr    : highest-priority index for this selection
//   onehot : selected line as a one-hot vector (zero when vec is empty)
//   idx    : binary index of the selected line
//   any    : vec has at least one set bit
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    onehot = arb_pkg::rr_pick(vec, ptr);
    idx    = onehot_idx(onehot);
    any    = |vec;
  end

endmodule

// File: rtl/onehot_req_arbiter.sv
// Round-robin arbiter for 8 request lines. Requests are latched into a
// pending set; one pending line at a time is offered as a one-hot grant
// that is held until the consumer accepts it.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   req       : level request lines, OR-ed into the pending set every edge
//   gnt_ready : consumer accepts the current grant this cycle
//   grant     : registered one-hot grant, zero when gnt_valid is low
//   gnt_valid : grant holds a valid one-hot value
//   pend_o    : pending register, for debug/status
module onehot_req_arbiter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             gnt_ready,
  output logic [N_REQ-1:0] grant,
  output logic             gnt_valid,
  output logic [N_REQ-1:0] pend_o
);

  state_t           state;
  logic [N_REQ-1:0] pend;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;

  logic [N_REQ-1:0] accepted;
  logic [N_REQ-1:0] pend_next;
  logic [N_REQ-1:0] cand;
  logic [IDX_W-1:0] cand_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  // In IDLE the selector looks at the pending register from the pointer.
  // In GRANT it looks at what remains after the current grant is accepted,
  // including this cycle's requests, starting just past the granted line.
  // A request on the accepted line re-enters through req, so it survives.
  always_comb begin
    accepted = '0;
    cand     = pend;
    cand_ptr = ptr;
    if (state == ST_GRANT) begin
      cand     = (pend & ~grant) | req;
      cand_ptr = gnt_idx + IDX_W'(1);
      if (gnt_ready) accepted = grant;
    end
    pend_next = (pend & ~accepted) | req;
  end

  rr_pick u_pick (
    .vec    (cand),
    .ptr    (cand_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend      <= '0;
      ptr       <= '0;
      gnt_idx   <= '0;
      grant     <= '0;
      gnt_valid <= 1'b0;
    end else begin
      pend <= pend_next;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant     <= pick_oh;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Without ready the grant is simply held.
          if (gnt_ready) begin
            ptr <= cand_ptr;
            if (pick_any) begin
              grant   <= pick_oh;
              gnt_idx <= pick_idx;
            end else begin
              grant     <= '0;
              gnt_valid <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        default: begin
          grant     <= '0;
          gnt_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign pend_o = pend;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Self-checking bench for onehot_req_arbiter: reference model of the
// arbitration rules plus directed vectors with hand-computed grants.
module tb_onehot_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       gnt_ready;
  logic [7:0] grant;
  logic       gnt_valid;
  logic [7:0] pend_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // reference model state
  bit [7:0] m_pend;
  int       m_ptr;
  bit       m_valid;
  int       m_idx;

  onehot_req_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_ready (gnt_ready),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .pend_o    (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_set(input bit [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic bit [7:0] m_grant();
    bit [7:0] g;
    g = 8'h00;
    if (m_valid) g[m_idx] = 1'b1;
    return g;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs in force at it.
  task automatic model_update();
    bit [7:0] acc;
    bit [7:0] nxt;
    bit [7:0] cnd;
    if (!rst_n) begin
      m_pend  = 8'h00;
      m_ptr   = 0;
      m_valid = 0;
      m_idx   = 0;
    end else begin
      acc = (m_valid && gnt_ready) ? m_grant() : 8'h00;
      nxt = (m_pend & ~acc) | req;
      if (!m_valid) begin
        if (m_pend != 0) begin
          m_idx   = first_set(m_pend, m_ptr);
          m_valid = 1;
        end
      end else if (gnt_ready) begin
        m_ptr = (m_idx + 1) % 8;
        cnd   = (m_pend & ~m_grant()) | req;
        if (cnd != 0) m_idx = first_set(cnd, m_ptr);
        else          m_valid = 0;
      end
      m_pend = nxt;
    end
  endtask

  task automatic step(input logic rn, input logic [7:0] r, input logic rd);
    rst_n     = rn;
    req       = r;
    gnt_ready = rd;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Per-cycle comparison against the model and structural invariants.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_grant", grant, m_grant());
      check("model_valid", {7'd0, gnt_valid}, {7'd0, m_valid});
      check("model_pend", pend_o, m_pend);
      check("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
      check("valid_vs_grant", {7'd0, gnt_valid}, {7'd0, (grant != 8'h00)});
      if (gnt_valid) check("grant_in_pend", grant & ~pend_o, 8'h00);
    end
  end

  typedef struct {
    logic [7:0] r;
    logic       rd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    rst_n     = 1'b0;
    req       = 8'h00;
    gnt_ready = 1'b0;

    // Reset held with all requests and ready asserted.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'hFF, 1'b1);
      chk_en = 1;
      check("rst_grant", grant, 8'h00);
      check("rst_valid", {7'd0, gnt_valid}, 8'h00);
      check("rst_pend", pend_o, 8'h00);
    end

    // First sampling edge latches pend; grant follows one edge later.
    step(1'b1, 8'hFF, 1'b1);
    check("lat_valid_t", {7'd0, gnt_valid}, 8'h00);
    check("lat_pend_t", pend_o, 8'hFF);
    step(1'b1, 8'hFF, 1'b1);
    check("first_grant", grant, 8'h01);

    // Round-robin sweep, one accepted grant per cycle.
    for (int k = 1; k <= 9; k++) begin
      logic [7:0] exp;
      exp = 8'h01 << (k % 8);
      step(1'b1, 8'hFF, 1'b1);
      check("sweep_grant", grant, exp);
      check("sweep_valid", {7'd0, gnt_valid}, 8'h01);
    end

    // Drain the remaining pending lines.
    for (int k = 0; k < 10; k++) step(1'b1, 8'h00, 1'b1);
    check("drain_valid", {7'd0, gnt_valid}, 8'h00);
    check("drain_pend", pend_o, 8'h00);

    // Stall: grant held while ready is low.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h24, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'h00, 1'b0);
      check("stall_grant", grant, 8'h04);
    end
    step(1'b1, 8'h00, 1'b1);
    check("stall_next", grant, 8'h20);
    step(1'b1, 8'h00, 1'b1);
    check("stall_idle", grant, 8'h00);
    check("stall_idle_v", {7'd0, gnt_valid}, 8'h00);

    // Pointer wrap: grant line 5 leaves the pointer at 6.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check("wrap_g5", grant, 8'h20);
    step(1'b1, 8'h00, 1'b1);
    check("wrap_idle", {7'd0, gnt_valid}, 8'h00);
    step(1'b1, 8'h41, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check("wrap_g6", grant, 8'h40);
    step(1'b1, 8'h00, 1'b1);
    check("wrap_g0", grant, 8'h01);
    step(1'b1, 8'h00, 1'b1);
    check("wrap_end", {7'd0, gnt_valid}, 8'h00);

    // Same-bit re-request during accept keeps bit 3 pending.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h28, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check("rereq_g3", grant, 8'h08);
    step(1'b1, 8'h08, 1'b1);
    check("rereq_g5", grant, 8'h20);
    check("rereq_pend", pend_o, 8'h28);
    step(1'b1, 8'h00, 1'b1);
    check("rereq_g3b", grant, 8'h08);
    step(1'b1, 8'h00, 1'b1);
    check("rereq_end", {7'd0, gnt_valid}, 8'h00);

    // Mid-operation reset discards grant and pending set.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check("mid_grant", grant, 8'h10);
    check("mid_pend", pend_o, 8'hF0);
    step(1'b0, 8'h00, 1'b0);
    check("mid_rst_g", grant, 8'h00);
    check("mid_rst_p", pend_o, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b1, 8'h00, 1'b1);
    check("mid_quiet", {7'd0, gnt_valid}, 8'h00);

    // Mixed vectors, including new higher-priority requests during accept.
    tbl[0]  = '{8'h81, 1'b0};
    tbl[1]  = '{8'h00, 1'b1};
    tbl[2]  = '{8'h02, 1'b1};
    tbl[3]  = '{8'h18, 1'b0};
    tbl[4]  = '{8'h01, 1'b1};
    tbl[5]  = '{8'h00, 1'b1};
    tbl[6]  = '{8'hC3, 1'b0};
    tbl[7]  = '{8'h00, 1'b1};
    tbl[8]  = '{8'h10, 1'b1};
    tbl[9]  = '{8'h00, 1'b0};
    tbl[10] = '{8'h00, 1'b1};
    tbl[11] = '{8'h00, 1'b1};
    for (int k = 0; k < 12; k++) step(1'b1, tbl[k].r, tbl[k].rd);
    for (int k = 0; k < 12; k++) step(1'b1, 8'h00, 1'b1);
    check("final_idle", {7'd0, gnt_valid}, 8'h00);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
